// File: rtl/count_load_conditioner_pkg.sv
// Shared constants and helpers for the count/load button conditioner.
package count_cond_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_CYCLES   = 64;

  localparam int CH_LOAD  = 0;
  localparam int CH_COUNT = 1;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_load_conditioner_if.sv
// Button/switch inputs and conditioned strobe outputs of the conditioner.
interface count_load_conditioner_if #(
  parameter int WIDTH = 4
) ();
  logic             Count_btn;
  logic             Load_btn;
  logic [WIDTH-1:0] Data_sw;
  logic             Count;
  logic             Load;
  logic [WIDTH-1:0] Data_out;
  logic             Busy;

  modport master (
    output Count_btn, Load_btn, Data_sw,
    input  Count, Load, Data_out, Busy
  );

  modport slave (
    input  Count_btn, Load_btn, Data_sw,
    output Count, Load, Data_out, Busy
  );
endinterface

// File: rtl/count_load_conditioner_debounce_sync_ch.sv
// One button channel: 2-flop synchronizer, debounce filter, accepted level.
// rise is a combinational pulse on the edge the filter accepts a 0->1 change.
module debounce_sync_ch
  import count_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic Clear,
  input  logic raw_in,
  output logic stable,
  output logic rise,
  output logic busy
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = raw_in;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
      rise     = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Clear) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign busy   = |cnt_q;

endmodule

// File: rtl/count_load_conditioner.sv
// Count/Load strobe conditioner: strobes one cycle after the edge a press is accepted.
// No backpressure; COUNT_AUTO_REPEAT_EN adds auto-repeat of held Count presses.
module count_load_conditioner
  import count_cond_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic                    CLK,
  input logic                    Clear,
  count_load_conditioner_if.slave bus
);

  logic [1:0] raw, stable, rise, busy;
  logic       count_req;

  assign raw[CH_LOAD]  = bus.Load_btn;
  assign raw[CH_COUNT] = bus.Count_btn;

  debounce_sync_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_ch (
    .CLK    (CLK),
    .Clear  (Clear),
    .raw_in (raw[CH_LOAD]),
    .stable (stable[CH_LOAD]),
    .rise   (rise[CH_LOAD]),
    .busy   (busy[CH_LOAD])
  );

  debounce_sync_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_count_ch (
    .CLK    (CLK),
    .Clear  (Clear),
    .raw_in (raw[CH_COUNT]),
    .stable (stable[CH_COUNT]),
    .rise   (rise[CH_COUNT]),
    .busy   (busy[CH_COUNT])
  );

`ifdef COUNT_AUTO_REPEAT_EN
  localparam int            RW       = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_run, rep_fire;

  // Repeat timer is measured from the previous Count strobe, real or repeated.
  always_comb begin
    rep_run  = stable[CH_COUNT] & ~stable[CH_LOAD];
    rep_fire = rep_run && (rep_q == RPT_LAST);
    if (!rep_run || rise[CH_LOAD] || rise[CH_COUNT] || rep_fire) begin
      rep_d = '0;
    end else begin
      rep_d = rep_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Clear) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign count_req = rise[CH_COUNT] | rep_fire;
`else
  logic unused_cfg;
  assign unused_cfg = ^{stable, 32'(REPEAT_CYCLES)};
  assign count_req  = rise[CH_COUNT];
`endif

  logic [WIDTH-1:0] data_s1_q, data_s1_d;
  logic [WIDTH-1:0] data_s2_q, data_s2_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             count_q, count_d;
  logic             load_q, load_d;

  // Load wins a same-edge collision; the Count press is dropped, not deferred.
  always_comb begin
    data_s1_d  = bus.Data_sw;
    data_s2_d  = data_s1_q;
    load_d     = rise[CH_LOAD];
    count_d    = count_req & ~rise[CH_LOAD];
    data_out_d = rise[CH_LOAD] ? data_s2_q : data_out_q;
  end

  always_ff @(posedge CLK) begin
    if (!Clear) begin
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      data_out_q <= '0;
      count_q    <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
      load_q     <= load_d;
    end
  end

  assign bus.Count    = count_q;
  assign bus.Load     = load_q;
  assign bus.Data_out = data_out_q;
  assign bus.Busy     = |busy;

endmodule

// File: tb/tb_count_load_conditioner.sv
// Scoreboard bench for count_load_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_count_load_conditioner;

  localparam int K_COUNT = 1;
  localparam int K_LOAD  = 2;

  typedef struct {
    int         kind;
    int         edge_n;
    logic [3:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic Clear;
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  count_load_conditioner_if #(.WIDTH(4)) bus ();

  count_load_conditioner #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .CLK   (CLK),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input int kind, input int edge_n, input logic [3:0] data);
    exp_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    e.data   = data;
    sb.push_back(e);
  endtask

  // Every strobe the DUT emits must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (bus.Count || bus.Load) begin
      chk("excl", 32'(bus.Count & bus.Load), 32'd0);
      if (sb.size() == 0) begin
        chk("unexp_strobe", {30'd0, bus.Count, bus.Load}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind", bus.Load ? K_LOAD : K_COUNT, 32'(e.kind));
        chk("edge", 32'(edge_cnt), 32'(e.edge_n));
        if (e.kind == K_LOAD) chk("data", 32'(bus.Data_out), 32'(e.data));
      end
    end
  end

  initial begin
    int k;
    Clear         = 1'b0;
    bus.Count_btn = 1'b0;
    bus.Load_btn  = 1'b0;
    bus.Data_sw   = 4'b0000;
    step(3);
    chk("rst_count", 32'(bus.Count), 32'd0);
    chk("rst_load", 32'(bus.Load), 32'd0);
    chk("rst_data", 32'(bus.Data_out), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    Clear = 1'b1;
    step(3);

    // Clean press held 38 cycles; repeats land every 8 edges when enabled.
    k = edge_cnt;
    bus.Count_btn = 1'b1;
    push(K_COUNT, k + 6, 4'b0);
`ifdef COUNT_AUTO_REPEAT_EN
    push(K_COUNT, k + 14, 4'b0);
    push(K_COUNT, k + 22, 4'b0);
    push(K_COUNT, k + 30, 4'b0);
    push(K_COUNT, k + 38, 4'b0);
`endif
    for (int i = 1; i <= 38; i++) begin
      step(1);
      if (i <= 7) chk("press_busy", 32'(bus.Busy), 32'((i >= 3 && i <= 5) ? 1 : 0));
    end
    bus.Count_btn = 1'b0;
    step(20);
    chk("press_busy_end", 32'(bus.Busy), 32'd0);
    chk("press_sb", 32'(sb.size()), 32'd0);

    // Two-cycle glitch is filtered out.
    bus.Count_btn = 1'b1;
    step(2);
    bus.Count_btn = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      step(1);
      chk("glitch_busy", 32'(bus.Busy), 32'((i == 3 || i == 4) ? 1 : 0));
    end
    step(20);
    chk("glitch_busy_end", 32'(bus.Busy), 32'd0);
    chk("glitch_sb", 32'(sb.size()), 32'd0);

    // Load captures switches; later switch changes do not leak through.
    bus.Data_sw = 4'b1010;
    step(5);
    k = edge_cnt;
    bus.Load_btn = 1'b1;
    push(K_LOAD, k + 6, 4'b1010);
    step(12);
    bus.Load_btn = 1'b0;
    step(12);
    bus.Data_sw = 4'b0110;
    step(10);
    chk("load_hold", 32'(bus.Data_out), 32'b1010);
    chk("load_sb", 32'(sb.size()), 32'd0);

    // Simultaneous presses: Load only, Count dropped.
    k = edge_cnt;
    bus.Load_btn  = 1'b1;
    bus.Count_btn = 1'b1;
    push(K_LOAD, k + 6, 4'b0110);
    step(15);
    bus.Load_btn  = 1'b0;
    bus.Count_btn = 1'b0;
    step(15);
    chk("simul_data", 32'(bus.Data_out), 32'b0110);
    chk("simul_sb", 32'(sb.size()), 32'd0);

    // Reset mid-debounce, button still held after Clear returns.
    k = edge_cnt;
    bus.Count_btn = 1'b1;
    step(3);
    Clear = 1'b0;
    step(1);
    chk("midrst_count", 32'(bus.Count), 32'd0);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_data", 32'(bus.Data_out), 32'd0);
    step(1);
    Clear = 1'b1;
    push(K_COUNT, k + 11, 4'b0);
    step(7);
    bus.Count_btn = 1'b0;
    step(15);
    chk("midrst_busy_end", 32'(bus.Busy), 32'd0);
    chk("final_sb", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
